// File: rtl/timer_pkg.sv
// Shared definitions for the memory-mapped countdown timer: register
// offsets, CTRL bit positions, mode codes and the FSM state encoding.
package timer_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_RELOAD  = 2'd1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

  // Only the reload code reloads; codes 2 and 3 fall back to one-shot.
  function automatic logic is_reload(input logic [1:0] mode);
    return mode == MODE_RELOAD;
  endfunction

endpackage

// File: rtl/timer_counter_if.sv
// Bridge-side bus of one timer instance: shared address/data, per-instance
// write strobe, read data and interrupt request.
interface timer_counter_if;
  logic [31:0] addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;
  logic        irq;

  modport master (output addr, output we, output din, input dout, input irq);
  modport slave  (input addr, input we, input din, output dout, output irq);
endinterface

// File: rtl/timer_prescaler.sv
// Step-strobe generator: divides the CNT-state stepping rate by PRESCALE.
// Only instantiated when TIMER_PRESCALE_EN is defined.
module timer_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic run,
  output logic tick
);

  logic [15:0] pre_cnt;

  assign tick = run && (pre_cnt == 16'(PRESCALE - 1));

  // Zeroed on LOAD, counts while in CNT and wraps on each strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_cnt <= '0;
    end else if (clr) begin
      pre_cnt <= '0;
    end else if (run) begin
      if (tick) pre_cnt <= '0;
      else      pre_cnt <= pre_cnt + 16'd1;
    end
  end

endmodule

// File: rtl/timer_counter.sv
// Countdown timer peripheral with CTRL/PRESET/COUNT registers, one-shot and
// auto-reload modes and a maskable interrupt flag.
// Optional macro TIMER_PRESCALE_EN: COUNT steps once every PRESCALE cycles.
module timer_counter
  import timer_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  timer_counter_if.slave   bus
);

  logic [3:0]  ctrl;
  logic [31:0] preset;
  logic [31:0] count;
  logic        irq_flag;
  state_t      state;
  logic        step;

  logic [1:0]  sel;
  logic        en;
  logic [1:0]  mode;
  logic        unused_bits;

  assign sel  = bus.addr[3:2];
  assign en   = ctrl[CTRL_EN];
  assign mode = ctrl[CTRL_MODE_HI:CTRL_MODE_LO];
  assign unused_bits = ^{bus.addr[31:4], bus.addr[1:0]};

`ifdef TIMER_PRESCALE_EN
  timer_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clr   (state == ST_LOAD),
    .run   (state == ST_CNT),
    .tick  (step)
  );
`else
  localparam int unused_prescale = PRESCALE;
  assign step = 1'b1;
`endif

  // Register file, countdown FSM and interrupt flag; the FSM sees the
  // pre-edge register values, bus writes land on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl     <= '0;
      preset   <= '0;
      count    <= '0;
      irq_flag <= 1'b0;
      state    <= ST_IDLE;
    end else begin
      // Lowest priority: a one-shot flag is acknowledged by any CTRL/PRESET
      // write; a set from the FSM below in the same cycle overrides it.
      if (bus.we && !is_reload(mode) && (sel == REG_CTRL || sel == REG_PRESET))
        irq_flag <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (en) state <= ST_LOAD;
        end
        ST_LOAD: begin
          count <= preset;
          state <= ST_CNT;
        end
        ST_CNT: begin
          if (!en) begin
            state <= ST_IDLE;
          end else if (step) begin
            if (count > 32'd1) begin
              count <= count - 32'd1;
            end else begin
              count    <= '0;
              irq_flag <= 1'b1;
              state    <= ST_INT;
            end
          end
        end
        ST_INT: begin
          if (is_reload(mode)) irq_flag <= 1'b0;
          else                 ctrl[CTRL_EN] <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      // Bus writes take precedence over the FSM's own EN clear.
      if (bus.we) begin
        case (sel)
          REG_CTRL:   ctrl   <= bus.din[3:0];
          REG_PRESET: preset <= bus.din;
          default:    ;
        endcase
      end
    end
  end

  // Combinational read mux over addr[3:2].
  always_comb begin
    bus.dout = '0;
    case (sel)
      REG_CTRL:   bus.dout = {28'd0, ctrl};
      REG_PRESET: bus.dout = preset;
      REG_COUNT:  bus.dout = count;
      default:    bus.dout = '0;
    endcase
  end

  assign bus.irq = irq_flag & ctrl[CTRL_IM];

endmodule

// File: tb/tb_timer_counter.sv
// Bench for timer_counter: randomized PRESET values checked against
// closed-form timing of the countdown, interrupt and reload behaviour.
module tb_timer_counter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;

  timer_counter_if bus();

  timer_counter #(.PRESCALE(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Advance one clock; return 1 ns after the rising edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Single-cycle bus write; returns 1 ns after the write edge.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.addr = a;
    bus.din  = d;
    bus.we   = 1'b1;
    cycle();
    bus.we   = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    bus.addr = a;
    #1;
    d = bus.dout;
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    bus.we = 1'b0;
    cycle();
    cycle();
    reset  = 1'b0;
  endtask

  // COUNT t cycles after the enabling CTRL write edge: unchanged for two
  // cycles, then PRESET, then one lower per cycle down to zero.
  function automatic logic [31:0] model_count(int t, int p, logic [31:0] c0);
    if (t < 2) return c0;
    if (p > t - 2) return 32'(p - (t - 2));
    return 32'd0;
  endfunction

  // Cycle offset of the flag rising after the enabling write edge.
  function automatic int model_flag_t(int p);
    return ((p == 0) ? 1 : p) + 2;
  endfunction

  task automatic test_reset();
    logic [31:0] d;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      rd(32'(i * 4), d);
      total++;
      if (d !== 32'd0) begin
        bad++;
        $display("FAIL reset_read addr=%0h got=%0h want=0", i * 4, d);
      end
    end
    total++;
    if (bus.irq !== 1'b0) begin
      bad++;
      $display("FAIL reset_irq got=%b want=0", bus.irq);
    end
  endtask

  task automatic test_oneshot(input int p);
    logic [31:0] d;
    int ft;
    do_reset();
    ft = model_flag_t(p);
    wr(32'h4, 32'(p));
    wr(32'h0, 32'h9);
    for (int t = 0; t <= ft + 2; t++) begin
      rd(32'h8, d);
      total++;
      if (d !== model_count(t, p, 32'd0)) begin
        bad++;
        $display("FAIL oneshot_count p=%0d t=%0d got=%0d want=%0d", p, t, d, model_count(t, p, 32'd0));
      end
      total++;
      if (bus.irq !== (t >= ft)) begin
        bad++;
        $display("FAIL oneshot_irq p=%0d t=%0d got=%b want=%b", p, t, bus.irq, (t >= ft));
      end
      if (t < ft + 2) cycle();
    end
    rd(32'h0, d);
    total++;
    if (d !== 32'h8) begin
      bad++;
      $display("FAIL oneshot_ctrl_en_clear got=%0h want=8", d);
    end
    wr(32'h4, 32'($urandom_range(1, 100)));
    total++;
    if (bus.irq !== 1'b0) begin
      bad++;
      $display("FAIL oneshot_ack_irq got=%b want=0", bus.irq);
    end
  endtask

  task automatic test_reload(input int p);
    logic [31:0] d;
    int ft, per;
    logic want;
    do_reset();
    ft  = model_flag_t(p);
    per = p + 3;
    wr(32'h4, 32'(p));
    wr(32'h0, 32'hB);
    for (int t = 0; t <= ft + 3 * per + 1; t++) begin
      want = (t >= ft) && (((t - ft) % per) == 0);
      total++;
      if (bus.irq !== want) begin
        bad++;
        $display("FAIL reload_irq p=%0d t=%0d got=%b want=%b", p, t, bus.irq, want);
      end
      cycle();
    end
    rd(32'h0, d);
    total++;
    if (d !== 32'hB) begin
      bad++;
      $display("FAIL reload_ctrl got=%0h want=b", d);
    end
  endtask

  task automatic test_freeze(input int p, input int k);
    logic [31:0] d;
    logic [31:0] frozen;
    int ft;
    do_reset();
    wr(32'h4, 32'(p));
    wr(32'h0, 32'h9);
    for (int i = 0; i < k; i++) cycle();
    wr(32'h0, 32'h8);
    frozen = model_count(k + 1, p, 32'd0);
    for (int i = 0; i < 5; i++) begin
      rd(32'h8, d);
      total++;
      if (d !== frozen) begin
        bad++;
        $display("FAIL freeze_count p=%0d k=%0d got=%0d want=%0d", p, k, d, frozen);
      end
      total++;
      if (bus.irq !== 1'b0) begin
        bad++;
        $display("FAIL freeze_irq got=%b want=0", bus.irq);
      end
      cycle();
    end
    ft = model_flag_t(p);
    wr(32'h0, 32'h9);
    for (int t = 0; t <= ft; t++) begin
      rd(32'h8, d);
      total++;
      if (d !== model_count(t, p, frozen)) begin
        bad++;
        $display("FAIL restart_count t=%0d got=%0d want=%0d", t, d, model_count(t, p, frozen));
      end
      total++;
      if (bus.irq !== (t >= ft)) begin
        bad++;
        $display("FAIL restart_irq t=%0d got=%b want=%b", t, bus.irq, (t >= ft));
      end
      if (t < ft) cycle();
    end
  endtask

  task automatic test_masked();
    logic [31:0] d;
    do_reset();
    wr(32'h4, 32'h0);
    wr(32'h0, 32'h1);
    for (int t = 0; t <= 6; t++) begin
      total++;
      if (bus.irq !== 1'b0) begin
        bad++;
        $display("FAIL masked_irq t=%0d got=%b want=0", t, bus.irq);
      end
      cycle();
    end
    rd(32'h0, d);
    total++;
    if (d !== 32'h0) begin
      bad++;
      $display("FAIL masked_ctrl got=%0h want=0", d);
    end
    wr(32'h0, 32'h8);
    total++;
    if (bus.irq !== 1'b0) begin
      bad++;
      $display("FAIL unmask_after_ack got=%b want=0", bus.irq);
    end
    rd(32'h0, d);
    total++;
    if (d !== 32'h8) begin
      bad++;
      $display("FAIL unmask_ctrl got=%0h want=8", d);
    end
  endtask

  task automatic test_reset_mid(input int p);
    logic [31:0] d;
    do_reset();
    wr(32'h4, 32'(p));
    wr(32'h0, 32'h9);
    for (int t = 0; t < model_flag_t(p); t++) cycle();
    total++;
    if (bus.irq !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset_irq got=%b want=1", bus.irq);
    end
    reset    = 1'b1;
    bus.addr = 32'h4;
    bus.din  = $urandom();
    bus.we   = 1'b1;
    cycle();
    reset    = 1'b0;
    bus.we   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rd(32'(i * 4), d);
      total++;
      if (d !== 32'd0) begin
        bad++;
        $display("FAIL midreset_read addr=%0h got=%0h want=0", i * 4, d);
      end
    end
    total++;
    if (bus.irq !== 1'b0) begin
      bad++;
      $display("FAIL midreset_irq got=%b want=0", bus.irq);
    end
  endtask

  task automatic test_ro_writes(input int p);
    logic [31:0] d;
    do_reset();
    wr(32'h4, 32'(p));
    wr(32'h0, 32'h9);
    for (int t = 1; t <= 3; t++) cycle();
    wr(32'h8, 32'hFFFF);
    wr(32'hC, $urandom());
    for (int t = 5; t <= 7; t++) begin
      rd(32'h8, d);
      total++;
      if (d !== model_count(t, p, 32'd0)) begin
        bad++;
        $display("FAIL ro_count t=%0d got=%0d want=%0d", t, d, model_count(t, p, 32'd0));
      end
      rd(32'hC, d);
      total++;
      if (d !== 32'd0) begin
        bad++;
        $display("FAIL reserved_read got=%0h want=0", d);
      end
      cycle();
    end
  endtask

  initial begin
    bus.addr = '0;
    bus.din  = '0;
    bus.we   = 1'b0;
    test_reset();
    test_oneshot(5);
    test_oneshot(0);
    test_oneshot($urandom_range(1, 12));
    test_reload(2);
    test_reload($urandom_range(1, 6));
    begin
      int p;
      p = $urandom_range(8, 20);
      test_freeze(10, 5);
      test_freeze(p, $urandom_range(3, p - 1));
    end
    test_masked();
    test_reset_mid($urandom_range(1, 3));
    test_ro_writes($urandom_range(8, 12));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
